// File: rtl/id_issue_stage.sv
// id_issue_stage: two-slot VLIW decode/issue with bypassed 8x32 register file, load-use stall and jump/flush squash.
module id_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] p1_aluInstr,
  input  logic [15:0] p1_memInstr,
  input  logic [31:0] p1_pc,
  input  logic        flush,
  input  logic        wb_aluWrite,
  input  logic        wb_memWrite,
  input  logic [2:0]  wb_aluRd,
  input  logic [2:0]  wb_memRd,
  input  logic [31:0] wb_aluData,
  input  logic [31:0] wb_memData,
  output logic        pcWrite,
  output logic        p1_pipeline_regWrite,
  output logic        isJump,
  output logic [31:0] pc_jumpTarget,
  output logic        isException,
  output logic        p2_valid,
  output logic [3:0]  p2_aluOp,
  output logic [31:0] p2_aluA,
  output logic [31:0] p2_aluB,
  output logic [2:0]  p2_aluRd,
  output logic        p2_aluRegWrite,
  output logic        p2_isBranch,
  output logic [31:0] p2_branchTarget,
  output logic        p2_memRead,
  output logic        p2_memWrite,
  output logic [31:0] p2_memBase,
  output logic [31:0] p2_memOffset,
  output logic [31:0] p2_storeData,
  output logic [2:0]  p2_memRd
);
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rd;
    logic        rw;
    logic        br;
    logic [31:0] bt;
    logic        mr;
    logic        mw;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sd;
    logic [2:0]  mrd;
  } p2_t;
  p2_t p2_q, p2_d;
  logic [31:0] rf [1:7];
  logic [31:0] rv [8];
  logic squash;
  logic [3:0] ao, mo;
  logic [2:0] a_rs, a_rt, m_rs, m_rt;
  logic [31:0] a_imm, m_imm;
  logic a_rr, a_addi, a_brn, m_lw, m_sw, m_j, illegal, hazard, live, stall, issue;
  // rv is the bypassed view of the file; it is also exactly the next-state of each entry
  always_comb begin
    rv[0] = '0;
    for (int i = 1; i < 8; i++)
      rv[i] = (wb_memWrite && wb_memRd == i[2:0]) ? wb_memData :
              (wb_aluWrite && wb_aluRd == i[2:0]) ? wb_aluData : rf[i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 1; i < 8; i++) rf[i] <= '0;
    else for (int i = 1; i < 8; i++) rf[i] <= rv[i];
  assign ao = p1_aluInstr[15:12];
  assign mo = p1_memInstr[15:12];
  assign a_rs = p1_aluInstr[8:6];
  assign a_rt = p1_aluInstr[5:3];
  assign m_rs = p1_memInstr[8:6];
  assign m_rt = p1_memInstr[5:3];
  assign a_imm = {{26{p1_aluInstr[5]}}, p1_aluInstr[5:0]};
  assign m_imm = {{26{p1_memInstr[5]}}, p1_memInstr[5:0]};
  assign a_rr = ao inside {4'd1, 4'd2, 4'd3, 4'd4};
  assign a_addi = ao == 4'd5;
  assign a_brn = ao == 4'd12;
  assign m_lw = mo == 4'd8;
  assign m_sw = mo == 4'd9;
  assign m_j = mo == 4'd10;
  assign illegal = !(ao == 4'd0 || a_rr || a_addi || a_brn) || !(mo == 4'd0 || m_lw || m_sw || m_j);
  // only source fields an opcode actually reads can create a load-use hazard
  assign hazard = p2_q.mr && p2_q.mrd != 3'd0 &&
                  (((a_rr || a_addi || a_brn) && a_rs == p2_q.mrd) ||
                   ((a_rr || a_brn) && a_rt == p2_q.mrd) ||
                   ((m_lw || m_sw) && m_rs == p2_q.mrd) ||
                   (m_sw && m_rt == p2_q.mrd));
  assign live = !reset && !squash && !flush;
  assign stall = live && hazard;
  assign issue = live && !stall && !illegal;
  assign pcWrite = !stall;
  assign p1_pipeline_regWrite = !stall;
  assign isJump = live && m_j && !stall;
  assign isException = live && illegal && !stall;
  assign pc_jumpTarget = {p1_pc[31:14], p1_memInstr[11:0], 2'b00};
  always_comb begin
    p2_d = '0;
    if (issue) begin
      p2_d.valid = 1'b1;
      p2_d.op = ao;
      p2_d.a = rv[a_rs];
      p2_d.b = a_addi ? a_imm : rv[a_rt];
      p2_d.rd = p1_aluInstr[11:9];
      p2_d.rw = a_rr || a_addi;
      p2_d.br = a_brn;
      p2_d.bt = p1_pc + {a_imm[29:0], 2'b00};
      p2_d.mr = m_lw;
      p2_d.mw = m_sw;
      p2_d.base = rv[m_rs];
      p2_d.off = m_imm;
      p2_d.sd = rv[m_rt];
      p2_d.mrd = p1_memInstr[11:9];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p2_q <= '0;
      squash <= 1'b0;
    end else begin
      p2_q <= p2_d;
      squash <= flush || isJump;
    end
  assign {p2_valid, p2_aluOp, p2_aluA, p2_aluB, p2_aluRd, p2_aluRegWrite, p2_isBranch, p2_branchTarget,
          p2_memRead, p2_memWrite, p2_memBase, p2_memOffset, p2_storeData, p2_memRd} = p2_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: scoreboard bench for the decode/issue stage.
module tb_id_issue_stage;
  logic clk = 1'b0, reset;
  logic [15:0] p1_aluInstr, p1_memInstr;
  logic [31:0] p1_pc;
  logic flush, wb_aluWrite, wb_memWrite;
  logic [2:0] wb_aluRd, wb_memRd;
  logic [31:0] wb_aluData, wb_memData;
  logic pcWrite, p1_pipeline_regWrite, isJump, isException;
  logic [31:0] pc_jumpTarget;
  logic p2_valid, p2_aluRegWrite, p2_isBranch, p2_memRead, p2_memWrite;
  logic [3:0] p2_aluOp;
  logic [31:0] p2_aluA, p2_aluB, p2_branchTarget, p2_memBase, p2_memOffset, p2_storeData;
  logic [2:0] p2_aluRd, p2_memRd;
  typedef struct packed {
    logic v;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [2:0] rd;
    logic rw, br, mr, mw;
    logic [31:0] base, off, sd;
    logic [2:0] mrd;
  } p2_t;
  p2_t obs, got, e;
  p2_t exp_q[$];
  int checks = 0, failures = 0;
  id_issue_stage dut (
    .clk(clk), .reset(reset), .p1_aluInstr(p1_aluInstr), .p1_memInstr(p1_memInstr), .p1_pc(p1_pc),
    .flush(flush), .wb_aluWrite(wb_aluWrite), .wb_memWrite(wb_memWrite), .wb_aluRd(wb_aluRd),
    .wb_memRd(wb_memRd), .wb_aluData(wb_aluData), .wb_memData(wb_memData), .pcWrite(pcWrite),
    .p1_pipeline_regWrite(p1_pipeline_regWrite), .isJump(isJump), .pc_jumpTarget(pc_jumpTarget),
    .isException(isException), .p2_valid(p2_valid), .p2_aluOp(p2_aluOp), .p2_aluA(p2_aluA),
    .p2_aluB(p2_aluB), .p2_aluRd(p2_aluRd), .p2_aluRegWrite(p2_aluRegWrite), .p2_isBranch(p2_isBranch),
    .p2_branchTarget(p2_branchTarget), .p2_memRead(p2_memRead), .p2_memWrite(p2_memWrite),
    .p2_memBase(p2_memBase), .p2_memOffset(p2_memOffset), .p2_storeData(p2_storeData), .p2_memRd(p2_memRd)
  );
  always #5 clk = ~clk;
  assign obs = {p2_valid, p2_aluOp, p2_aluA, p2_aluB, p2_aluRd, p2_aluRegWrite, p2_isBranch,
                p2_memRead, p2_memWrite, p2_memBase, p2_memOffset, p2_storeData, p2_memRd};
  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, rs, rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction
  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, rs, input logic [5:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic p2_t alu_e(input logic [3:0] op, input logic [31:0] a, b, input logic [2:0] rd, input logic rw);
    p2_t r;
    r = '0;
    r.v = 1'b1;
    r.op = op;
    r.a = a;
    r.b = b;
    r.rd = rd;
    r.rw = rw;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] alu, mem);
    p1_aluInstr = alu;
    p1_memInstr = mem;
  endtask
  task automatic wb(input logic aw, input logic [2:0] ard, input logic [31:0] ad,
                    input logic mw, input logic [2:0] mrd, input logic [31:0] md);
    wb_aluWrite = aw; wb_aluRd = ard; wb_aluData = ad;
    wb_memWrite = mw; wb_memRd = mrd; wb_memData = md;
  endtask
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; p1_pc = 32'h4010;
    wb(0, 0, 0, 0, 0, 0);
    drive(16'h7000, {4'hA, 12'h003});
    #3;
    checks++; if ({pcWrite, p1_pipeline_regWrite} !== 2'b11) begin failures++; $display("FAIL reset_enables got=%b exp=11", {pcWrite, p1_pipeline_regWrite}); end
    checks++; if ({isJump, isException} !== 2'b00) begin failures++; $display("FAIL reset_jump_exc got=%b exp=00", {isJump, isException}); end
    checks++; if (obs !== '0) begin failures++; $display("FAIL reset_p2 got=%h exp=0", obs); end
    tick();
    drive(16'h0, 16'h0);
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic test_add();
    drive(16'h0, 16'h0);
    wb(1, 3'd1, 32'd5, 1, 3'd2, 32'd7);
    exp_q.push_back(alu_e(0, 0, 0, 0, 0));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL wb_nop_issue got=%h exp=%h", got, e); end
    wb(0, 0, 0, 0, 0, 0);
    drive(enc_r(4'd1, 3'd3, 3'd1, 3'd2), 16'h0);
    exp_q.push_back(alu_e(4'd1, 32'd5, 32'd7, 3'd3, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL add_issue got=%h exp=%h", got, e); end
  endtask
  task automatic test_bypass();
    wb(0, 0, 0, 1, 3'd4, 32'h1234);
    drive(enc_i(4'd5, 3'd5, 3'd4, 6'h3F), 16'h0);
    exp_q.push_back(alu_e(4'd5, 32'h1234, 32'hFFFF_FFFF, 3'd5, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL addi_bypass got=%h exp=%h", got, e); end
    wb(1, 3'd4, 32'hAAAA, 1, 3'd4, 32'hBBBB);
    drive(16'h0, 16'h0);
    exp_q.push_back(alu_e(0, 0, 0, 0, 0));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL wb_conflict_nop got=%h exp=%h", got, e); end
    wb(0, 0, 0, 0, 0, 0);
    drive(enc_r(4'd3, 3'd6, 3'd4, 3'd1), 16'h0);
    exp_q.push_back(alu_e(4'd3, 32'hBBBB, 32'd5, 3'd6, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL wb_conflict_read got=%h exp=%h", got, e); end
  endtask
  task automatic test_load_use();
    drive(16'h0, enc_i(4'd8, 3'd2, 3'd1, 6'd0));
    e = alu_e(0, 0, 0, 0, 0); e.mr = 1'b1; e.base = 32'd5; e.mrd = 3'd2;
    exp_q.push_back(e);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL lw_issue got=%h exp=%h", got, e); end
    drive(enc_r(4'd1, 3'd3, 3'd2, 3'd1), 16'h0);
    #1;
    checks++; if ({pcWrite, p1_pipeline_regWrite} !== 2'b00) begin failures++; $display("FAIL stall_enables got=%b exp=00", {pcWrite, p1_pipeline_regWrite}); end
    exp_q.push_back('0);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL stall_bubble got=%h exp=%h", got, e); end
    checks++; if ({pcWrite, p1_pipeline_regWrite} !== 2'b11) begin failures++; $display("FAIL stall_release got=%b exp=11", {pcWrite, p1_pipeline_regWrite}); end
    exp_q.push_back(alu_e(4'd1, 32'd7, 32'd5, 3'd3, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL after_stall_issue got=%h exp=%h", got, e); end
    drive(16'h0, enc_i(4'd8, 3'd0, 3'd1, 6'd0));
    e = alu_e(0, 0, 0, 0, 0); e.mr = 1'b1; e.base = 32'd5;
    exp_q.push_back(e);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL lw_r0_issue got=%h exp=%h", got, e); end
    drive(enc_r(4'd1, 3'd3, 3'd0, 3'd1), 16'h0);
    #1;
    checks++; if (pcWrite !== 1'b1) begin failures++; $display("FAIL lw_r0_nostall got=%b exp=1", pcWrite); end
    exp_q.push_back(alu_e(4'd1, 32'd0, 32'd5, 3'd3, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL lw_r0_use got=%h exp=%h", got, e); end
  endtask
  task automatic test_branch();
    p1_pc = 32'h100;
    drive(enc_i(4'd12, 3'd0, 3'd1, 6'b010111), 16'h0);
    e = alu_e(4'd12, 32'd5, 32'd7, 3'd0, 0); e.br = 1'b1;
    exp_q.push_back(e);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL brn_issue got=%h exp=%h", got, e); end
    checks++; if (p2_branchTarget !== 32'h15C) begin failures++; $display("FAIL brn_target got=%h exp=0000015c", p2_branchTarget); end
  endtask
  task automatic test_jump();
    p1_pc = 32'h0000_4010;
    drive(16'h0, {4'hA, 12'h003});
    #1;
    checks++; if (isJump !== 1'b1) begin failures++; $display("FAIL jump_flag got=%b exp=1", isJump); end
    checks++; if (pc_jumpTarget !== 32'h0000_400C) begin failures++; $display("FAIL jump_target got=%h exp=0000400c", pc_jumpTarget); end
    tick();
    checks++; if ({p2_valid, p2_memRead, p2_memWrite, p2_aluRegWrite} !== 4'b1000) begin failures++; $display("FAIL jump_p2 got=%b exp=1000", {p2_valid, p2_memRead, p2_memWrite, p2_aluRegWrite}); end
    drive(16'h7000, {4'hA, 12'h003});
    #1;
    checks++; if ({isJump, isException, pcWrite} !== 3'b001) begin failures++; $display("FAIL squash_flags got=%b exp=001", {isJump, isException, pcWrite}); end
    exp_q.push_back('0);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL squash_bubble got=%h exp=%h", got, e); end
  endtask
  task automatic test_flush_stall();
    drive(16'h0, enc_i(4'd8, 3'd2, 3'd1, 6'd0));
    e = alu_e(0, 0, 0, 0, 0); e.mr = 1'b1; e.base = 32'd5; e.mrd = 3'd2;
    exp_q.push_back(e);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL flush_lw got=%h exp=%h", got, e); end
    drive(enc_r(4'd1, 3'd3, 3'd2, 3'd1), 16'h0);
    #1;
    checks++; if (pcWrite !== 1'b0) begin failures++; $display("FAIL flush_prestall got=%b exp=0", pcWrite); end
    flush = 1'b1;
    #1;
    checks++; if ({pcWrite, p1_pipeline_regWrite} !== 2'b11) begin failures++; $display("FAIL flush_release got=%b exp=11", {pcWrite, p1_pipeline_regWrite}); end
    exp_q.push_back('0);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL flush_bubble got=%h exp=%h", got, e); end
    flush = 1'b0;
    exp_q.push_back('0);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL post_flush_squash got=%h exp=%h", got, e); end
    exp_q.push_back(alu_e(4'd1, 32'd7, 32'd5, 3'd3, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL post_flush_issue got=%h exp=%h", got, e); end
  endtask
  task automatic test_illegal();
    drive(16'h7000, 16'h0);
    #1;
    checks++; if ({isException, pcWrite} !== 2'b11) begin failures++; $display("FAIL illegal_flags got=%b exp=11", {isException, pcWrite}); end
    exp_q.push_back('0);
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL illegal_bubble got=%h exp=%h", got, e); end
  endtask
  task automatic test_async_reset();
    drive(16'h0, enc_i(4'd8, 3'd2, 3'd1, 6'd0));
    tick();
    drive(enc_r(4'd1, 3'd3, 3'd2, 3'd1), 16'h0);
    #1;
    checks++; if (pcWrite !== 1'b0) begin failures++; $display("FAIL areset_prestall got=%b exp=0", pcWrite); end
    reset = 1'b1;
    #1;
    checks++; if ({pcWrite, p1_pipeline_regWrite} !== 2'b11 || obs !== '0) begin failures++; $display("FAIL areset_clear got=%b/%h exp=11/0", {pcWrite, p1_pipeline_regWrite}, obs); end
    drive(enc_r(4'd1, 3'd3, 3'd1, 3'd2), 16'h0);
    @(negedge clk) reset = 1'b0;
    exp_q.push_back(alu_e(4'd1, 32'd0, 32'd0, 3'd3, 1));
    tick(); got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL areset_rf_cleared got=%h exp=%h", got, e); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_load_use();
    test_branch();
    test_jump();
    test_illegal();
    test_flush_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
